// File: rtl/commit_trace_streamer.sv
// Commit trace streamer: captures retired-instruction records into a FIFO and
// serialises each one as a short burst of 32-bit valid/ready words.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing being sent; pops the next record when FIFO non-empty
// S_HDR   | presenting header word (marker, rd, has_data, lost, seq)
// S_PC    | presenting retired PC
// S_INSTR | presenting instruction word (last word when rd == 0)
// S_DATA  | presenting writeback value (only when rd != 0)
module commit_trace_streamer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     update_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [31:0]              instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    output logic                     m_valid_o,
    output logic [31:0]              m_data_o,
    output logic                     m_last_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_INSTR,
        S_DATA
    } state_t;

    state_t state_q, state_d;

    // record storage, one array per field
    logic [15:0]     mem_seq   [DEPTH];
    logic            mem_lost  [DEPTH];
    logic [4:0]      mem_rd    [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic [XLEN-1:0] mem_data  [DEPTH];

    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    // record currently being serialised
    logic [15:0]     hold_seq;
    logic            hold_lost;
    logic [4:0]      hold_rd;
    logic [XLEN-1:0] hold_pc;
    logic [31:0]     hold_instr;
    logic [XLEN-1:0] hold_data;

    logic [15:0]     seq_q;
    logic            lost_q;
    logic [15:0]     drop_q;

    logic capture, push, pop, pop_req, drop, has_data, fifo_empty, fifo_full;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign has_data   = (hold_rd != 5'd0);
    assign capture    = update_i && enable_i;
    assign pop        = pop_req && !fifo_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push       = capture && (!fifo_full || pop);
    assign drop       = capture && !push;

    assign level_o    = count;
    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign drop_cnt_o = drop_q;

    // FIFO write side, pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_seq[wr_ptr]   <= seq_q;
                mem_lost[wr_ptr]  <= lost_q;
                mem_rd[wr_ptr]    <= reg_addr_i;
                mem_pc[wr_ptr]    <= pc_i;
                mem_instr[wr_ptr] <= instr_i;
                mem_data[wr_ptr]  <= reg_data_i;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // load the holding register from the FIFO head on every pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_seq   <= '0;
            hold_lost  <= 1'b0;
            hold_rd    <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
            hold_data  <= '0;
        end else if (pop) begin
            hold_seq   <= mem_seq[rd_ptr];
            hold_lost  <= mem_lost[rd_ptr];
            hold_rd    <= mem_rd[rd_ptr];
            hold_pc    <= mem_pc[rd_ptr];
            hold_instr <= mem_instr[rd_ptr];
            hold_data  <= mem_data[rd_ptr];
        end
    end

    // sequence number, lost flag and saturating drop counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_q  <= '0;
            lost_q <= 1'b0;
            drop_q <= '0;
        end else begin
            if (capture) begin
                seq_q <= seq_q + 16'd1;
            end
            if (push) begin
                lost_q <= 1'b0;
            end else if (drop) begin
                lost_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, pop request and word mux
    always_comb begin
        state_d   = state_q;
        pop_req   = 1'b0;
        m_valid_o = 1'b0;
        m_data_o  = '0;
        m_last_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop_req = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                m_valid_o = 1'b1;
                m_data_o  = {8'hA5, hold_rd, has_data, hold_lost, 1'b0, hold_seq};
                if (m_ready_i) state_d = S_PC;
            end
            S_PC: begin
                m_valid_o = 1'b1;
                m_data_o  = hold_pc;
                if (m_ready_i) state_d = S_INSTR;
            end
            S_INSTR: begin
                m_valid_o = 1'b1;
                m_data_o  = hold_instr;
                m_last_o  = !has_data;
                if (m_ready_i) begin
                    if (has_data) begin
                        state_d = S_DATA;
                    end else if (!fifo_empty) begin
                        pop_req = 1'b1;
                        state_d = S_HDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                m_valid_o = 1'b1;
                m_data_o  = hold_data;
                m_last_o  = 1'b1;
                if (m_ready_i) begin
                    if (!fifo_empty) begin
                        pop_req = 1'b1;
                        state_d = S_HDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
